// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer-width helper and payload/pointer types
package fifo_pkg;

    // Defaults shared by the FIFO family; individual blocks may override by parameter.
    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1;

    // Pointer width: index bits plus one wrap bit that separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;
    typedef logic [FIFO_PTR_WIDTH-1:0]  fifo_ptr_t;

endpackage

// File: rtl/fifo_storage.sv
// rtl/fifo_storage.sv - DEPTH x DATA_WIDTH register array, sync write, async read
//
// Ports:
//   clk_in   - clock, write on rising edge
//   areset_b - asynchronous active-low reset, clears every entry
//   wr_en    - store wr_data at wr_addr
//   wr_addr  - write index
//   wr_data  - write payload
//   rd_addr  - read index
//   rd_data  - combinational contents of mem[rd_addr]
module fifo_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk_in,
    input  logic                     areset_b,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_buffer_ctrl.sv
// rtl/fifo_buffer_ctrl.sv - synchronous FIFO: pointers, status flags, overflow error
//
// Ports:
//   clk_in, areset_b        - clock and asynchronous active-low reset
//   flush                   - synchronous clear of both pointers (storage untouched)
//   wr_valid/wr_data/wr_ready - write handshake; wr_ready = not full
//   rd_valid/rd_data/rd_ready - read handshake; rd_data is zero while empty
//   fill_count              - stored entries, 0..DEPTH
//   almost_full/almost_empty - fill_count >= AF_LEVEL / <= AE_LEVEL
//   ovf_err/err_clr         - sticky write-while-full flag and its clear
module fifo_buffer_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                        clk_in,
    input  logic                        areset_b,
    input  logic                        flush,
    input  logic                        wr_valid,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_ready,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [ptr_width(DEPTH)-1:0] fill_count,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        ovf_err,
    input  logic                        err_clr
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  ovf_err_q, ovf_err_d;
    logic                  full, empty, wr_en, rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Flush discards both requests of its cycle.
    assign wr_en = wr_valid && !full && !flush;
    assign rd_en = rd_ready && !empty && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_err_d = ovf_err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // DEPTH is a power of two, so a plain increment wraps the index
            // and toggles the wrap bit together.
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (err_clr) begin
            ovf_err_d = 1'b0;
        end else if (wr_valid && full) begin
            ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk_in   (clk_in),
        .areset_b (areset_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr_q[AW-1:0]),
        .wr_data  (wr_data),
        .rd_addr  (rd_ptr_q[AW-1:0]),
        .rd_data  (mem_rdata)
    );

    // Pointer difference modulo 2^PW is the occupancy, wrap bit included.
    assign fill_count   = wr_ptr_q - rd_ptr_q;
    assign wr_ready     = !full;
    assign rd_valid     = !empty;
    assign rd_data      = empty ? '0 : mem_rdata;
    assign almost_full  = (fill_count >= AF_LVL);
    assign almost_empty = (fill_count <= AE_LVL);
    assign ovf_err      = ovf_err_q;

endmodule
